id_ex_stage_reg: RTL and testbench

//  ID/EX pipeline register of the 5-stage MIPS core, directly downstream of SignExt and the register file.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/id_ex_stage_reg_hazard_detect.sv | 28 ++
 rtl/id_ex_stage_reg.sv | 135 +++++++++++++
 tb/tb_id_ex_stage_reg.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bus widths, control-bundle bit positions and the
// ID/EX register update selector.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;
    localparam int CTRL_W = 11;
    localparam int CNT_W  = 16;

    localparam int REG_WRITE  = 0;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 2;
    localparam int MEM_TO_REG = 3;
    localparam int ALU_SRC    = 4;
    localparam int REG_DST    = 5;
    localparam int BRANCH     = 6;
    localparam int ALU_OP_LSB = 7;
    localparam int ALU_OP_MSB = 10;

    typedef enum logic [1:0] {
        UPD_LOAD,
        UPD_HOLD,
        UPD_BUBBLE,
        UPD_FLUSH
    } upd_e;

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Load-use hazard detector: the instruction in EX is a load whose destination
// is a source of the instruction in ID.
module hazard_detect #(
    parameter int IDX_W = pipe_pkg::IDX_W
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [IDX_W-1:0] ex_rt,
    input  logic [IDX_W-1:0] id_rs,
    input  logic [IDX_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_valid,
    input  logic             flush,
    input  logic             ex_stall,
    output logic             load_use_stall
);

    logic w_idx_match;
    logic w_hz;

    assign w_idx_match = (ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt));
    // Register 0 is hard-wired, so a load into it can never create a dependency.
    assign w_hz        = ex_valid & ex_mem_read & (ex_rt != '0) & w_idx_match;

    // A flush or downstream stall already decides this edge; no bubble needed.
    assign load_use_stall = id_valid & w_hz & ~flush & ~ex_stall;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded instruction state, inserts a bubble
// on load-use hazards and counts those bubbles.
module id_ex_stage_reg #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int IDX_W  = pipe_pkg::IDX_W,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = pipe_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [IDX_W-1:0]  id_rs,
    input  logic [IDX_W-1:0]  id_rt,
    input  logic [IDX_W-1:0]  id_rd,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [IDX_W-1:0]  ex_rs,
    output logic [IDX_W-1:0]  ex_rt,
    output logic [IDX_W-1:0]  ex_rd,
    output logic              load_use_stall,
    output logic              id_hold,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm_ext;
    logic [IDX_W-1:0]  r_rs;
    logic [IDX_W-1:0]  r_rt;
    logic [IDX_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_bubble_count;

    logic              w_load_use;
    pipe_pkg::upd_e    w_upd;

    hazard_detect #(
        .IDX_W (IDX_W)
    ) u_hazard_detect (
        .ex_valid       (r_valid),
        .ex_mem_read    (r_ctrl[pipe_pkg::MEM_READ]),
        .ex_rt          (r_rt),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_valid       (id_valid),
        .flush          (flush),
        .ex_stall       (ex_stall),
        .load_use_stall (w_load_use)
    );

    // Flush outranks stall, which outranks the load-use bubble.
    always_comb begin
        w_upd = pipe_pkg::UPD_LOAD;
        if (flush)
            w_upd = pipe_pkg::UPD_FLUSH;
        else if (ex_stall)
            w_upd = pipe_pkg::UPD_HOLD;
        else if (w_load_use)
            w_upd = pipe_pkg::UPD_BUBBLE;
    end

    // NOTE: every sequential assignment uses <= so all registers sample the
    // pre-edge values of each other; a blocking = here would chain updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm_ext <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
        end else begin
            case (w_upd)
                pipe_pkg::UPD_FLUSH, pipe_pkg::UPD_BUBBLE: begin
                    r_valid   <= 1'b0;
                    r_ctrl    <= '0;
                    r_rs_data <= '0;
                    r_rt_data <= '0;
                    r_imm_ext <= '0;
                    r_rs      <= '0;
                    r_rt      <= '0;
                    r_rd      <= '0;
                end
                pipe_pkg::UPD_HOLD: begin
                    r_valid <= r_valid;
                end
                default: begin
                    r_valid   <= id_valid;
                    // An empty slot must never carry write enables into EX.
                    r_ctrl    <= id_valid ? id_ctrl : '0;
                    r_rs_data <= id_rs_data;
                    r_rt_data <= id_rt_data;
                    r_imm_ext <= id_imm_ext;
                    r_rs      <= id_rs;
                    r_rt      <= id_rt;
                    r_rd      <= id_rd;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_bubble_count <= '0;
        else if ((w_upd == pipe_pkg::UPD_BUBBLE) && (r_bubble_count != '1))
            r_bubble_count <= r_bubble_count + 1'b1;
    end

    assign ex_valid       = r_valid;
    assign ex_ctrl        = r_ctrl;
    assign ex_rs_data     = r_rs_data;
    assign ex_rt_data     = r_rt_data;
    assign ex_imm_ext     = r_imm_ext;
    assign ex_rs          = r_rs;
    assign ex_rt          = r_rt;
    assign ex_rd          = r_rd;
    assign load_use_stall = w_load_use;
    assign id_hold        = ex_stall | w_load_use;
    assign bubble_count   = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;
    localparam int CTRL_W = 11;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 2;

    localparam logic [CTRL_W-1:0] C_LW  = 11'h01B;
    localparam logic [CTRL_W-1:0] C_ADD = 11'h121;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              id_valid = 0, id_uses_rt = 0, ex_stall = 0, flush = 0;
    logic [CTRL_W-1:0] id_ctrl = '0;
    logic [DATA_W-1:0] id_rs_data = '0, id_rt_data = '0, id_imm_ext = '0;
    logic [IDX_W-1:0]  id_rs = '0, id_rt = '0, id_rd = '0;

    logic              ex_valid, load_use_stall, id_hold;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [IDX_W-1:0]  ex_rs, ex_rt, ex_rd;
    logic [CNT_W-1:0]  bubble_count;

    logic              s_ex_valid, s_load_use_stall, s_id_hold;
    logic [CTRL_W-1:0] s_ex_ctrl;
    logic [DATA_W-1:0] s_ex_rs_data, s_ex_rt_data, s_ex_imm_ext;
    logic [IDX_W-1:0]  s_ex_rs, s_ex_rt, s_ex_rd;
    logic [SAT_W-1:0]  s_bubble_count;

    id_ex_stage_reg #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .load_use_stall(load_use_stall), .id_hold(id_hold), .bubble_count(bubble_count)
    );

    // Narrow counter instance so saturation is reachable in a few hazards.
    id_ex_stage_reg #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CTRL_W(CTRL_W), .CNT_W(SAT_W)) sat_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_stall(ex_stall), .flush(flush),
        .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl), .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data),
        .ex_imm_ext(s_ex_imm_ext), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
        .load_use_stall(s_load_use_stall), .id_hold(s_id_hold), .bubble_count(s_bubble_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: contents of the EX slot and the number of bubbles.
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_rs_data, m_rt_data, m_imm;
    logic [IDX_W-1:0]  m_rs, m_rt, m_rd;
    int                m_cnt;

    function automatic logic m_lus();
        logic dep;
        dep = (m_rt == id_rs) || (id_uses_rt && (m_rt == id_rt));
        return id_valid && m_valid && m_ctrl[1] && (m_rt != 0) && dep && !flush && !ex_stall;
    endfunction

    task automatic m_clear();
        m_valid = 0; m_ctrl = '0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clear();
            m_cnt = 0;
        end else begin
            logic lus;
            lus = m_lus();
            if (flush) m_clear();
            else if (ex_stall) begin end
            else if (lus) begin m_clear(); m_cnt++; end
            else begin
                m_valid = id_valid; m_ctrl = id_valid ? id_ctrl : '0;
                m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm_ext;
                m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            end
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            #2;
            if (!rst) begin
                check("m_valid", ex_valid, m_valid);
                check("m_ctrl", ex_ctrl, m_ctrl);
                check("m_rs_data", ex_rs_data, m_rs_data);
                check("m_rt_data", ex_rt_data, m_rt_data);
                check("m_imm", ex_imm_ext, m_imm);
                check("m_rs", ex_rs, m_rs);
                check("m_rt", ex_rt, m_rt);
                check("m_rd", ex_rd, m_rd);
                check("m_lus", load_use_stall, m_lus());
                check("m_hold", id_hold, ex_stall | m_lus());
                check("m_count", bubble_count, (m_cnt > 65535) ? 65535 : m_cnt);
                check("m_sat_count", s_bubble_count, (m_cnt > 3) ? 3 : m_cnt);
                check("m_sat_valid", s_ex_valid, m_valid);
            end
        end
    end

    task automatic cyc(input logic v, input logic [CTRL_W-1:0] c, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [31:0] imm, input int rs, input int rt,
                       input int rd, input logic uses, input logic st, input logic fl);
        @(negedge clk);
        id_valid = v; id_ctrl = c; id_rs_data = rsd; id_rt_data = rtd; id_imm_ext = imm;
        id_rs = IDX_W'(rs); id_rt = IDX_W'(rt); id_rd = IDX_W'(rd); id_uses_rt = uses;
        ex_stall = st; flush = fl;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic hold_q;
        #12;
        check("rst_valid", ex_valid, 0);
        check("rst_ctrl", ex_ctrl, 0);
        check("rst_count", bubble_count, 0);
        @(negedge clk);
        rst = 0;
        cmp_en = 1;

        // Pass-through.
        cyc(1, C_ADD, 32'h1234, 32'h0, 32'hFFFF8000, 1, 2, 7, 1, 0, 0);
        edge_wait();
        check("t1_valid", ex_valid, 1);
        check("t1_rs_data", ex_rs_data, 32'h1234);
        check("t1_imm", ex_imm_ext, 32'hFFFF8000);
        check("t1_rd", ex_rd, 7);
        check("t1_ctrl", ex_ctrl, C_ADD);

        // Load-use: lw r5 in EX, add reading r5 in ID.
        cyc(1, C_LW, 0, 0, 4, 1, 5, 0, 0, 0, 0);
        edge_wait();
        cyc(1, C_ADD, 55, 66, 0, 5, 3, 8, 1, 0, 0);
        #1;
        check("t2_lus", load_use_stall, 1);
        check("t2_hold", id_hold, 1);
        edge_wait();
        check("t2_bubble_valid", ex_valid, 0);
        check("t2_bubble_ctrl", ex_ctrl, 0);
        check("t2_count", bubble_count, 1);
        cyc(1, C_ADD, 55, 66, 0, 5, 3, 8, 1, 0, 0);
        #1;
        check("t2_lus_gone", load_use_stall, 0);
        edge_wait();
        check("t2_add_valid", ex_valid, 1);
        check("t2_add_rs", ex_rs, 5);
        check("t2_add_rd", ex_rd, 8);
        check("t2_add_ctrl", ex_ctrl, C_ADD);

        // No hazard: load into r0, then rt-only match without rt use.
        cyc(1, C_LW, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        edge_wait();
        cyc(1, C_ADD, 0, 0, 0, 0, 0, 9, 1, 0, 0);
        #1;
        check("t3_rt0_lus", load_use_stall, 0);
        cyc(1, C_LW, 0, 0, 0, 1, 6, 0, 0, 0, 0);
        edge_wait();
        cyc(1, C_ADD, 0, 0, 0, 2, 6, 9, 0, 0, 0);
        #1;
        check("t3_rtonly_lus", load_use_stall, 0);
        edge_wait();
        check("t3_count", bubble_count, 1);
        check("t3_valid", ex_valid, 1);
        check("t3_rs", ex_rs, 2);

        // Downstream stall freezes EX for three cycles.
        for (int i = 0; i < 3; i++) begin
            cyc(1, C_ADD, 100 + i, 200 + i, i, 10 + i, i, i, 1, 1, 0);
            #1;
            check("t4_hold", id_hold, 1);
            check("t4_lus", load_use_stall, 0);
            edge_wait();
            check("t4_frozen_rs", ex_rs, 2);
            check("t4_frozen_rd", ex_rd, 9);
        end
        cyc(1, C_ADD, 77, 0, 0, 9, 1, 3, 1, 0, 0);
        edge_wait();
        check("t4_resume_rs", ex_rs, 9);
        check("t4_resume_data", ex_rs_data, 77);

        // Flush with stall and a pending hazard.
        cyc(1, C_LW, 0, 0, 0, 1, 4, 0, 0, 0, 0);
        edge_wait();
        cyc(1, C_ADD, 0, 0, 0, 4, 0, 2, 1, 1, 1);
        #1;
        check("t5_lus", load_use_stall, 0);
        check("t5_hold", id_hold, 1);
        edge_wait();
        check("t5_valid", ex_valid, 0);
        check("t5_ctrl", ex_ctrl, 0);
        check("t5_count", bubble_count, 1);

        // Four more hazards: wide counter reaches 5, narrow one sticks at 3.
        for (int i = 0; i < 4; i++) begin
            cyc(1, C_LW, 0, 0, 0, 1, 4, 0, 0, 0, 0);
            edge_wait();
            cyc(1, C_ADD, 0, 0, 0, 4, 0, 2, 1, 0, 0);
            edge_wait();
        end
        check("t6_count", bubble_count, 5);
        check("t6_sat", s_bubble_count, 3);

        // Asynchronous reset in mid-cycle.
        cyc(1, C_ADD, 32'hABCD, 1, 2, 3, 4, 5, 1, 0, 0);
        edge_wait();
        @(negedge clk);
        #3;
        rst = 1;
        #1;
        check("arst_valid", ex_valid, 0);
        check("arst_ctrl", ex_ctrl, 0);
        check("arst_data", ex_rs_data, 0);
        check("arst_count", bubble_count, 0);
        check("arst_sat", s_bubble_count, 0);

        // Randomized traffic; ID re-presents its instruction while held.
        hold_q = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst = 0;
            if (!hold_q) begin
                id_valid   = ($urandom_range(0, 7) != 0);
                id_ctrl    = CTRL_W'($urandom);
                id_ctrl[1] = 1'($urandom_range(0, 1));
                id_uses_rt = 1'($urandom_range(0, 1));
                id_rs_data = $urandom;
                id_rt_data = $urandom;
                id_imm_ext = $urandom;
                id_rs      = IDX_W'($urandom_range(0, 3));
                id_rt      = IDX_W'($urandom_range(0, 3));
                id_rd      = IDX_W'($urandom_range(0, 31));
            end
            ex_stall = ($urandom_range(0, 9) < 2);
            flush    = ($urandom_range(0, 9) == 0);
            #1;
            hold_q = ex_stall | m_lus();
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst = 1;
                hold_q = 0;
            end
        end
        @(negedge clk);
        rst = 0;
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
